// File: rtl/exc_ctrl.sv
// Exception / interrupt / ERET sequencer owning Status.EXL.
// Latency: exception redirect 3 cycles after acceptance, ERET redirect 2 cycles.
// Backpressure: none; requests arriving while busy are dropped, not queued.
//
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   exc_req/_code/_pc/_bd - synchronous exception from the pipeline
//   int_req, ie         - pending unmasked interrupt, Status.IE
//   eret_req, epc_rdata - ERET at commit, EPC read data
//   epc_we_h/_bd/_pc    - hardware EPC write (EPC unit applies the BD -4 adjust)
//   epc_r_h             - hardware EPC read strobe
//   cause_we/_code/_bd  - Cause update
//   exl                 - Status.EXL
//   flush, redirect_valid, redirect_pc - pipeline control
//   busy                - sequence in progress
module exc_ctrl #(
   parameter logic [31:0] EXC_VECTOR = 32'h8000_0180,
   parameter logic [4:0]  CODE_INT   = 5'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        exc_req,
   input  logic [4:0]  exc_code,
   input  logic [31:0] exc_pc,
   input  logic        exc_bd,
   input  logic        int_req,
   input  logic        ie,
   input  logic        eret_req,
   input  logic [31:0] epc_rdata,
   output logic        epc_we_h,
   output logic        epc_bd,
   output logic [31:0] epc_pc,
   output logic        epc_r_h,
   output logic        cause_we,
   output logic [4:0]  cause_code,
   output logic        cause_bd,
   output logic        exl,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        busy
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FLUSH   = 3'd1,
      ST_SAVE    = 3'd2,
      ST_VECTOR  = 3'd3,
      ST_ERET_RD = 3'd4,
      ST_ERET_GO = 3'd5
   } state_t;

   state_t      state_q, state_d;
   logic        exl_q, exl_d;
   logic [4:0]  code_q, code_d;
   logic [31:0] pc_q, pc_d;
   logic        bd_q, bd_d;
   // EXL value at acceptance: a nested exception must not overwrite EPC.
   logic        nested_q, nested_d;
   logic [31:0] epc_q, epc_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         exl_q    <= 1'b0;
         code_q   <= 5'd0;
         pc_q     <= 32'd0;
         bd_q     <= 1'b0;
         nested_q <= 1'b0;
         epc_q    <= 32'd0;
      end else begin
         state_q  <= state_d;
         exl_q    <= exl_d;
         code_q   <= code_d;
         pc_q     <= pc_d;
         bd_q     <= bd_d;
         nested_q <= nested_d;
         epc_q    <= epc_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      exl_d          = exl_q;
      code_d         = code_q;
      pc_d           = pc_q;
      bd_d           = bd_q;
      nested_d       = nested_q;
      epc_d          = epc_q;
      flush          = 1'b0;
      cause_we       = 1'b0;
      epc_we_h       = 1'b0;
      epc_r_h        = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;

      case (state_q)
         ST_IDLE: begin
            // Priority: exception > interrupt > ERET.
            if (exc_req) begin
               code_d   = exc_code;
               pc_d     = exc_pc;
               bd_d     = exc_bd;
               nested_d = exl_q;
               state_d  = ST_FLUSH;
            end else if (int_req && ie && !exl_q) begin
               code_d   = CODE_INT;
               pc_d     = exc_pc;
               bd_d     = exc_bd;
               nested_d = 1'b0;
               state_d  = ST_FLUSH;
            end else if (eret_req && exl_q) begin
               state_d  = ST_ERET_RD;
            end
         end
         ST_FLUSH: begin
            flush   = 1'b1;
            state_d = ST_SAVE;
         end
         ST_SAVE: begin
            cause_we = 1'b1;
            epc_we_h = !nested_q;
            exl_d    = 1'b1;
            state_d  = ST_VECTOR;
         end
         ST_VECTOR: begin
            redirect_valid = 1'b1;
            redirect_pc    = EXC_VECTOR;
            state_d        = ST_IDLE;
         end
         ST_ERET_RD: begin
            flush   = 1'b1;
            epc_r_h = 1'b1;
            epc_d   = epc_rdata;
            state_d = ST_ERET_GO;
         end
         ST_ERET_GO: begin
            redirect_valid = 1'b1;
            redirect_pc    = epc_q;
            exl_d          = 1'b0;
            state_d        = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign epc_pc     = pc_q;
   assign epc_bd     = bd_q;
   assign cause_code = code_q;
   assign cause_bd   = bd_q;
   assign exl        = exl_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_exc_ctrl.sv
module tb_exc_ctrl;

   localparam logic [31:0] VEC  = 32'h8000_0180;
   localparam logic [4:0]  CINT = 5'd0;

   logic        clk = 1'b0;
   logic        rst;
   logic        exc_req;
   logic [4:0]  exc_code;
   logic [31:0] exc_pc;
   logic        exc_bd;
   logic        int_req;
   logic        ie;
   logic        eret_req;
   logic [31:0] epc_rdata;
   logic        epc_we_h;
   logic        epc_bd;
   logic [31:0] epc_pc;
   logic        epc_r_h;
   logic        cause_we;
   logic [4:0]  cause_code;
   logic        cause_bd;
   logic        exl;
   logic        flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        busy;

   exc_ctrl #(.EXC_VECTOR(VEC), .CODE_INT(CINT)) dut (
      .clk(clk), .rst(rst),
      .exc_req(exc_req), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
      .int_req(int_req), .ie(ie), .eret_req(eret_req), .epc_rdata(epc_rdata),
      .epc_we_h(epc_we_h), .epc_bd(epc_bd), .epc_pc(epc_pc), .epc_r_h(epc_r_h),
      .cause_we(cause_we), .cause_code(cause_code), .cause_bd(cause_bd),
      .exl(exl), .flush(flush), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .busy(busy)
   );

   always #5 clk = ~clk;

   int vectors    = 0;
   int miscompares = 0;

   // Reference model: a queue of expected per-cycle output records. An
   // accepted request appends the whole sequence it will produce; an empty
   // queue means the block is idle.
   typedef struct packed {
      logic        flush;
      logic        epc_we;
      logic        epc_r;
      logic        cause_we;
      logic        rv;
      logic [31:0] rpc;
      logic [31:0] epc_pc;
      logic        epc_bd;
      logic [4:0]  code;
      logic        cbd;
      logic        set_exl;
      logic        clr_exl;
      logic        take_epc;
   } exp_t;

   exp_t mq[$];
   logic exl_m = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_in();
      exc_req  = 1'b0;
      exc_code = 5'd0;
      exc_pc   = 32'd0;
      exc_bd   = 1'b0;
      int_req  = 1'b0;
      ie       = 1'b0;
      eret_req = 1'b0;
   endtask

   task automatic model_reset();
      mq.delete();
      exl_m = 1'b0;
   endtask

   task automatic push_exc(input logic [4:0] code, input logic [31:0] pc, input logic bd);
      exp_t a, b, c;
      a = '0; a.flush = 1'b1;
      b = '0; b.cause_we = 1'b1; b.epc_we = !exl_m; b.epc_pc = pc; b.epc_bd = bd;
      b.code = code; b.cbd = bd; b.set_exl = 1'b1;
      c = '0; c.rv = 1'b1; c.rpc = VEC;
      mq.push_back(a);
      mq.push_back(b);
      mq.push_back(c);
   endtask

   task automatic push_eret();
      exp_t a, b;
      a = '0; a.flush = 1'b1; a.epc_r = 1'b1; a.take_epc = 1'b1;
      b = '0; b.rv = 1'b1; b.clr_exl = 1'b1;
      mq.push_back(a);
      mq.push_back(b);
   endtask

   task automatic check_outputs();
      exp_t e;
      e = (mq.size() > 0) ? mq[0] : '0;
      chk("flush", flush, e.flush);
      chk("epc_we_h", epc_we_h, e.epc_we);
      chk("epc_r_h", epc_r_h, e.epc_r);
      chk("cause_we", cause_we, e.cause_we);
      chk("redirect_valid", redirect_valid, e.rv);
      chk("redirect_pc", redirect_pc, e.rpc);
      chk("busy", busy, mq.size() > 0);
      chk("exl", exl, exl_m);
      if (e.cause_we) begin
         chk("epc_pc", epc_pc, e.epc_pc);
         chk("epc_bd", epc_bd, e.epc_bd);
         chk("cause_code", cause_code, e.code);
         chk("cause_bd", cause_bd, e.cbd);
      end
   endtask

   // Advance the model across the coming rising edge using current inputs.
   task automatic model_step();
      exp_t r, g;
      if (!rst) begin
         model_reset();
         return;
      end
      if (mq.size() > 0) begin
         r = mq.pop_front();
         if (r.set_exl) exl_m = 1'b1;
         if (r.clr_exl) exl_m = 1'b0;
         if (r.take_epc && mq.size() > 0) begin
            g = mq.pop_front();
            g.rpc = epc_rdata;
            mq.push_front(g);
         end
      end else if (exc_req) begin
         push_exc(exc_code, exc_pc, exc_bd);
      end else if (int_req && ie && !exl_m) begin
         push_exc(CINT, exc_pc, exc_bd);
      end else if (eret_req && exl_m) begin
         push_eret();
      end
   endtask

   // Called just after a falling edge with the next inputs already driven.
   task automatic cycle();
      check_outputs();
      model_step();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b0;
      clear_in();
      epc_rdata = 32'd0;
      repeat (2) @(negedge clk);

      // Reset state
      chk("rst_busy", busy, 0);
      chk("rst_exl", exl, 0);
      cycle();
      rst = 1'b1;

      // Plain exception, exl=0
      exc_req = 1'b1; exc_code = 5'd4; exc_pc = 32'h0040_0010; exc_bd = 1'b0;
      cycle();
      clear_in();
      chk("t1_flush", flush, 1);
      cycle();
      chk("t2_epc_we", epc_we_h, 1);
      chk("t2_cause_we", cause_we, 1);
      chk("t2_epc_pc", epc_pc, 32'h0040_0010);
      chk("t2_cause_code", cause_code, 5'd4);
      cycle();
      chk("t3_exl", exl, 1);
      chk("t3_rv", redirect_valid, 1);
      chk("t3_rpc", redirect_pc, 32'h8000_0180);
      cycle();
      chk("t4_idle", busy, 0);

      // Nested exception: EPC untouched
      exc_req = 1'b1; exc_code = 5'd8; exc_pc = 32'h0040_0100;
      cycle();
      clear_in();
      for (int i = 0; i < 3; i++) begin
         chk("nest_epc_we", epc_we_h, 0);
         if (i == 1) chk("nest_cause_we", cause_we, 1);
         if (i == 2) chk("nest_rpc", redirect_pc, VEC);
         cycle();
      end
      chk("nest_exl", exl, 1);

      // ERET
      eret_req = 1'b1;
      cycle();
      eret_req = 1'b0;
      epc_rdata = 32'h0040_0014;
      chk("eret_r", epc_r_h, 1);
      chk("eret_flush", flush, 1);
      cycle();
      epc_rdata = 32'd0;
      chk("eret_rv", redirect_valid, 1);
      chk("eret_rpc", redirect_pc, 32'h0040_0014);
      cycle();
      chk("eret_exl_clr", exl, 0);

      // ERET with exl=0 is ignored
      eret_req = 1'b1;
      cycle();
      eret_req = 1'b0;
      chk("eret_ign_busy", busy, 0);
      chk("eret_ign_r", epc_r_h, 0);

      // All three requests together: exception wins
      exc_req = 1'b1; int_req = 1'b1; eret_req = 1'b1; ie = 1'b1;
      exc_code = 5'd12; exc_pc = 32'h0040_0200; exc_bd = 1'b0;
      cycle();
      clear_in();
      cycle();
      chk("pri_cause_we", cause_we, 1);
      chk("pri_code", cause_code, 5'd12);
      cycle();
      cycle();
      chk("pri_idle", busy, 0);

      // Reset pulsed during SAVE
      exc_req = 1'b1; exc_code = 5'd5; exc_pc = 32'h0040_0300;
      cycle();
      clear_in();
      cycle();
      chk("rs_in_save", cause_we, 1);
      rst = 1'b0;
      #1;
      chk("rs_cause_we", cause_we, 0);
      chk("rs_epc_we", epc_we_h, 0);
      chk("rs_rv", redirect_valid, 0);
      chk("rs_rpc", redirect_pc, 0);
      chk("rs_busy", busy, 0);
      chk("rs_exl", exl, 0);
      chk("rs_epc_pc", epc_pc, 0);
      chk("rs_code", cause_code, 0);
      model_reset();
      cycle();
      cycle();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("rs_no_rv", redirect_valid, 0);
         cycle();
      end

      // Delay-slot exception, accepted on the first edge after a reset
      rst = 1'b0;
      #1;
      model_reset();
      cycle();
      rst = 1'b1;
      exc_req = 1'b1; exc_code = 5'd10; exc_pc = 32'h0040_0020; exc_bd = 1'b1;
      cycle();
      clear_in();
      chk("bd_first_flush", flush, 1);
      cycle();
      chk("bd_epc_bd", epc_bd, 1);
      chk("bd_epc_pc", epc_pc, 32'h0040_0020);
      chk("bd_cause_bd", cause_bd, 1);
      chk("bd_epc_we", epc_we_h, 1);
      cycle();
      cycle();

      // Randomized traffic against the model
      for (int n = 0; n < 2500; n++) begin
         exc_req   = ($urandom_range(0, 7) == 0);
         exc_code  = 5'($urandom);
         exc_pc    = $urandom & 32'hFFFF_FFFC;
         exc_bd    = 1'($urandom);
         int_req   = ($urandom_range(0, 3) == 0);
         ie        = 1'($urandom);
         eret_req  = ($urandom_range(0, 2) == 0);
         epc_rdata = $urandom;
         if ($urandom_range(0, 149) == 0) begin
            rst = 1'b0;
            #1;
            model_reset();
         end else begin
            rst = 1'b1;
         end
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
